// File: rtl/mem_bist_pkg.sv
// Shared types and data patterns for the dual-port RAM self-test controller.
package mem_bist_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WR_A = 3'd1,
        S_RD_B = 3'd2,
        S_WR_B = 3'd3,
        S_RD_A = 3'd4,
        S_DONE = 3'd5
    } state_t;

    // Pattern written through port A: idx*17 + seed. Callers truncate to DW,
    // which equals doing the arithmetic modulo 2^DW.
    function automatic logic [31:0] pa(input logic [31:0] idx, input logic [31:0] seed);
        return (idx * 32'd17) + seed;
    endfunction

    // Pattern written through port B: ~(idx*5 + seed), truncated to DW by callers.
    function automatic logic [31:0] pb(input logic [31:0] idx, input logic [31:0] seed);
        return ~((idx * 32'd5) + seed);
    endfunction

endpackage

// File: rtl/mem_bist_rd_check.sv
// Read-back checker: delays {valid, addr, expected} by the RAM read latency and
// compares against the selected port's read data, reporting the mismatch details.
module mem_bist_rd_check #(
    parameter int AW     = 6,
    parameter int DW     = 8,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          in_valid,
    input  logic [AW-1:0] in_addr,
    input  logic [DW-1:0] in_exp,
    input  logic          sel_b,
    input  logic [DW-1:0] q_a,
    input  logic [DW-1:0] q_b,
    output logic          mismatch,
    output logic [AW-1:0] mm_addr,
    output logic [DW-1:0] mm_exp,
    output logic [DW-1:0] mm_got
);

    logic          dl_v_r [RD_LAT];
    logic [AW-1:0] dl_a_r [RD_LAT];
    logic [DW-1:0] dl_e_r [RD_LAT];
    logic          mismatch_r;
    logic [AW-1:0] mm_addr_r;
    logic [DW-1:0] mm_exp_r;
    logic [DW-1:0] mm_got_r;
    logic [DW-1:0] q_sel_s;
    logic          miss_s;

    // Select the port being read and compare it with the oldest delay-line entry.
    always_comb begin
        q_sel_s = q_a;
        if (sel_b) begin
            q_sel_s = q_b;
        end else begin
            q_sel_s = q_a;
        end
        miss_s = dl_v_r[RD_LAT-1] && (q_sel_s != dl_e_r[RD_LAT-1]);
    end

    // Delay line shift and registered mismatch capture; flush drops pending reads.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < RD_LAT; k++) begin
                dl_v_r[k] <= 1'b0;
                dl_a_r[k] <= {AW{1'b0}};
                dl_e_r[k] <= {DW{1'b0}};
            end
            mismatch_r <= 1'b0;
            mm_addr_r  <= {AW{1'b0}};
            mm_exp_r   <= {DW{1'b0}};
            mm_got_r   <= {DW{1'b0}};
        end else if (flush) begin
            for (int k = 0; k < RD_LAT; k++) begin
                dl_v_r[k] <= 1'b0;
            end
            mismatch_r <= 1'b0;
        end else begin
            dl_v_r[0] <= in_valid;
            dl_a_r[0] <= in_addr;
            dl_e_r[0] <= in_exp;
            for (int k = 1; k < RD_LAT; k++) begin
                dl_v_r[k] <= dl_v_r[k-1];
                dl_a_r[k] <= dl_a_r[k-1];
                dl_e_r[k] <= dl_e_r[k-1];
            end
            mismatch_r <= miss_s;
            if (miss_s) begin
                mm_addr_r <= dl_a_r[RD_LAT-1];
                mm_exp_r  <= dl_e_r[RD_LAT-1];
                mm_got_r  <= q_sel_s;
            end
        end
    end

    assign mismatch = mismatch_r;
    assign mm_addr  = mm_addr_r;
    assign mm_exp   = mm_exp_r;
    assign mm_got   = mm_got_r;

endmodule

// File: rtl/mem_bist.sv
// Self-test controller for a dual-port RAM: write via A / read via B, then
// write via B / read via A, stopping at the first mismatching read.
module mem_bist #(
    parameter int AW     = 6,
    parameter int DW     = 8,
    parameter int RD_LAT = 1,
    parameter int SEED   = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          fail,
    output logic          err_port,
    output logic [AW-1:0] err_addr,
    output logic [DW-1:0] err_exp,
    output logic [DW-1:0] err_got,
    output logic [AW-1:0] addr_a,
    output logic [AW-1:0] addr_b,
    output logic [DW-1:0] data_a,
    output logic [DW-1:0] data_b,
    output logic          we_a,
    output logic          we_b,
    output logic          re_a,
    output logic          re_b,
    input  logic [DW-1:0] q_a,
    input  logic [DW-1:0] q_b
);
    import mem_bist_pkg::*;

    localparam int            DCW   = $clog2(RD_LAT + 1);
    localparam logic [DCW-1:0] DLAST = DCW'(RD_LAT - 1);
    localparam logic [AW-1:0] ZA    = {AW{1'b0}};
    localparam logic [DW-1:0] ZD    = {DW{1'b0}};
    localparam logic [AW-1:0] AMAX  = {AW{1'b1}};

    function automatic logic [DW-1:0] pat_a(input logic [AW-1:0] a);
        return DW'(pa(32'(a), 32'(SEED)));
    endfunction

    function automatic logic [DW-1:0] pat_b(input logic [AW-1:0] a);
        return DW'(pb(32'(a), 32'(SEED)));
    endfunction

    state_t         state_r;
    logic [AW-1:0]  cnt_r;
    logic [DCW-1:0] dcnt_r;
    logic           drain_r;
    logic           rd_port_r;
    logic           busy_r, done_r, fail_r, err_port_r;
    logic [AW-1:0]  err_addr_r, addr_a_r, addr_b_r;
    logic [DW-1:0]  err_exp_r, err_got_r, data_a_r, data_b_r;
    logic           we_a_r, we_b_r, re_a_r, re_b_r;

    logic [AW-1:0]  nxt_s;
    logic           start_ok_s, err_take_s, flush_s;
    logic           chk_v_s;
    logic [AW-1:0]  chk_a_s;
    logic [DW-1:0]  chk_e_s;
    logic           mm_s;
    logic [AW-1:0]  mm_addr_s;
    logic [DW-1:0]  mm_exp_s, mm_got_s;

    // Control decodes and the read descriptor handed to the checker.
    always_comb begin
        nxt_s      = cnt_r + {{(AW-1){1'b0}}, 1'b1};
        start_ok_s = start && ((state_r == S_IDLE) || (state_r == S_DONE));
        err_take_s = mm_s && !fail_r && (state_r != S_IDLE);
        flush_s    = start_ok_s || err_take_s;
        chk_v_s    = re_a_r || re_b_r;
        if (rd_port_r) begin
            chk_a_s = addr_b_r;
            chk_e_s = pat_a(addr_b_r);
        end else begin
            chk_a_s = addr_a_r;
            chk_e_s = pat_b(addr_a_r);
        end
    end

    mem_bist_rd_check #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT)) u_rd_check (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush_s),
        .in_valid (chk_v_s),
        .in_addr  (chk_a_s),
        .in_exp   (chk_e_s),
        .sel_b    (rd_port_r),
        .q_a      (q_a),
        .q_b      (q_b),
        .mismatch (mm_s),
        .mm_addr  (mm_addr_s),
        .mm_exp   (mm_exp_s),
        .mm_got   (mm_got_s)
    );

    // Test sequencer; every RAM-facing and status output is registered here.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r  <= S_IDLE;
            cnt_r    <= ZA;      dcnt_r <= {DCW{1'b0}};
            drain_r  <= 1'b0;    rd_port_r <= 1'b0;
            busy_r   <= 1'b0;    done_r <= 1'b0;    fail_r <= 1'b0;
            err_port_r <= 1'b0;  err_addr_r <= ZA;
            err_exp_r  <= ZD;    err_got_r  <= ZD;
            addr_a_r <= ZA;      addr_b_r <= ZA;
            data_a_r <= ZD;      data_b_r <= ZD;
            we_a_r <= 1'b0; we_b_r <= 1'b0; re_a_r <= 1'b0; re_b_r <= 1'b0;
        end else if (start_ok_s) begin
            state_r  <= S_WR_A;
            cnt_r    <= ZA;      dcnt_r <= {DCW{1'b0}};  drain_r <= 1'b0;
            busy_r   <= 1'b1;    done_r <= 1'b0;    fail_r <= 1'b0;
            err_port_r <= 1'b0;  err_addr_r <= ZA;
            err_exp_r  <= ZD;    err_got_r  <= ZD;
            we_a_r   <= 1'b1;    addr_a_r <= ZA;    data_a_r <= pat_a(ZA);
            re_a_r   <= 1'b0;    we_b_r <= 1'b0;    re_b_r <= 1'b0;
            addr_b_r <= ZA;      data_b_r <= ZD;
        end else if (err_take_s) begin
            // First mismatch wins; the checker is flushed on this same edge.
            state_r    <= S_DONE;
            busy_r     <= 1'b0;  done_r <= 1'b1;    fail_r <= 1'b1;
            err_port_r <= rd_port_r;
            err_addr_r <= mm_addr_s;
            err_exp_r  <= mm_exp_s;
            err_got_r  <= mm_got_s;
            drain_r  <= 1'b0;
            addr_a_r <= ZA;      addr_b_r <= ZA;
            data_a_r <= ZD;      data_b_r <= ZD;
            we_a_r <= 1'b0; we_b_r <= 1'b0; re_a_r <= 1'b0; re_b_r <= 1'b0;
        end else begin
            case (state_r)
                S_WR_A: begin
                    if (cnt_r == AMAX) begin
                        state_r  <= S_RD_B;
                        we_a_r   <= 1'b0;  addr_a_r <= ZA;  data_a_r <= ZD;
                        re_b_r   <= 1'b1;  addr_b_r <= ZA;
                        rd_port_r <= 1'b1; cnt_r <= ZA;
                    end else begin
                        cnt_r <= nxt_s; addr_a_r <= nxt_s; data_a_r <= pat_a(nxt_s);
                    end
                end
                S_RD_B: begin
                    if (!drain_r) begin
                        if (cnt_r == AMAX) begin
                            re_b_r <= 1'b0; addr_b_r <= ZA;
                            drain_r <= 1'b1; dcnt_r <= {DCW{1'b0}};
                        end else begin
                            cnt_r <= nxt_s; addr_b_r <= nxt_s;
                        end
                    end else if (dcnt_r == DLAST) begin
                        state_r <= S_WR_B; drain_r <= 1'b0; cnt_r <= ZA;
                        we_b_r  <= 1'b1;   addr_b_r <= ZA;  data_b_r <= pat_b(ZA);
                    end else begin
                        dcnt_r <= dcnt_r + {{(DCW-1){1'b0}}, 1'b1};
                    end
                end
                S_WR_B: begin
                    if (cnt_r == AMAX) begin
                        state_r  <= S_RD_A;
                        we_b_r   <= 1'b0;  addr_b_r <= ZA;  data_b_r <= ZD;
                        re_a_r   <= 1'b1;  addr_a_r <= ZA;
                        rd_port_r <= 1'b0; cnt_r <= ZA;
                    end else begin
                        cnt_r <= nxt_s; addr_b_r <= nxt_s; data_b_r <= pat_b(nxt_s);
                    end
                end
                S_RD_A: begin
                    if (!drain_r) begin
                        if (cnt_r == AMAX) begin
                            re_a_r <= 1'b0; addr_a_r <= ZA;
                            drain_r <= 1'b1; dcnt_r <= {DCW{1'b0}};
                        end else begin
                            cnt_r <= nxt_s; addr_a_r <= nxt_s;
                        end
                    end else if (dcnt_r == DLAST) begin
                        state_r <= S_DONE; drain_r <= 1'b0; cnt_r <= ZA;
                        busy_r  <= 1'b0;   done_r <= 1'b1;
                    end else begin
                        dcnt_r <= dcnt_r + {{(DCW-1){1'b0}}, 1'b1};
                    end
                end
                S_IDLE, S_DONE: begin
                    state_r <= state_r;
                end
                default: begin
                    state_r <= S_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign busy     = busy_r;
    assign done     = done_r;
    assign fail     = fail_r;
    assign err_port = err_port_r;
    assign err_addr = err_addr_r;
    assign err_exp  = err_exp_r;
    assign err_got  = err_got_r;
    assign addr_a   = addr_a_r;
    assign addr_b   = addr_b_r;
    assign data_a   = data_a_r;
    assign data_b   = data_b_r;
    assign we_a     = we_a_r;
    assign we_b     = we_b_r;
    assign re_a     = re_a_r;
    assign re_b     = re_b_r;

endmodule

// File: tb/tb_mem_bist.sv
// Bench for mem_bist: two instances (RD_LAT=1 and RD_LAT=2) on behavioural RAMs
// with injectable faults; per-run expectations flow through a scoreboard queue.
module tb_mem_bist;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, start_v;
    bit   sel;
    int   fault, lat2;
    int   checks = 0, errors = 0;

    logic busy1, done1, fail1, ep1, wa1, wb1, ra1, rb1;
    logic [5:0] ea1, aa1, ab1;
    logic [7:0] ee1, eg1, da1, db1, qa1, qb1;
    logic busy2, done2, fail2, ep2, wa2, wb2, ra2, rb2;
    logic [5:0] ea2, aa2, ab2;
    logic [7:0] ee2, eg2, da2, db2, qa2, qb2;

    mem_bist #(.AW(6), .DW(8), .RD_LAT(1), .SEED(0)) dut (
        .clk(clk), .rst_n(rst_n), .start(start_v & !sel),
        .busy(busy1), .done(done1), .fail(fail1), .err_port(ep1), .err_addr(ea1),
        .err_exp(ee1), .err_got(eg1), .addr_a(aa1), .addr_b(ab1), .data_a(da1),
        .data_b(db1), .we_a(wa1), .we_b(wb1), .re_a(ra1), .re_b(rb1),
        .q_a(qa1), .q_b(qb1));

    mem_bist #(.AW(6), .DW(8), .RD_LAT(2), .SEED(0)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start_v & sel),
        .busy(busy2), .done(done2), .fail(fail2), .err_port(ep2), .err_addr(ea2),
        .err_exp(ee2), .err_got(eg2), .addr_a(aa2), .addr_b(ab2), .data_a(da2),
        .data_b(db2), .we_a(wa2), .we_b(wb2), .re_a(ra2), .re_b(rb2),
        .q_a(qa2), .q_b(qb2));

    // RAM for the RD_LAT=1 instance: fault 1 = q_b[3] stuck at 0, fault 2 = port A ignores addr[0].
    logic [7:0] mem1 [64];
    always @(posedge clk) begin
        if (wa1) mem1[aa1] <= da1;
        if (wb1) mem1[ab1] <= db1;
        if (ra1) qa1 <= mem1[(fault == 2) ? {aa1[5:1], 1'b0} : aa1];
        if (rb1) qb1 <= mem1[ab1] & ((fault == 1) ? 8'hF7 : 8'hFF);
    end

    // RAM for the RD_LAT=2 instance with selectable 1- or 2-cycle read latency.
    logic [7:0] mem2 [64];
    logic [7:0] r1a, r1b;
    always @(posedge clk) begin
        if (wa2) mem2[aa2] <= da2;
        if (wb2) mem2[ab2] <= db2;
        if (ra2) r1a <= mem2[aa2];
        if (rb2) r1b <= mem2[ab2];
        if (lat2 == 2) begin
            qa2 <= r1a;
            qb2 <= r1b;
        end else begin
            if (ra2) qa2 <= mem2[aa2];
            if (rb2) qb2 <= mem2[ab2];
        end
    end

    logic m_busy, m_done, m_fail, m_ep, m_wa, m_wb, m_ra, m_rb;
    logic [5:0] m_ea, m_aa, m_ab;
    logic [7:0] m_ee, m_eg, m_da, m_db;
    assign m_busy = sel ? busy2 : busy1;
    assign m_done = sel ? done2 : done1;
    assign m_fail = sel ? fail2 : fail1;
    assign m_ep   = sel ? ep2   : ep1;
    assign m_ea   = sel ? ea2   : ea1;
    assign m_ee   = sel ? ee2   : ee1;
    assign m_eg   = sel ? eg2   : eg1;
    assign m_aa   = sel ? aa2   : aa1;
    assign m_ab   = sel ? ab2   : ab1;
    assign m_da   = sel ? da2   : da1;
    assign m_db   = sel ? db2   : db1;
    assign m_wa   = sel ? wa2   : wa1;
    assign m_wb   = sel ? wb2   : wb1;
    assign m_ra   = sel ? ra2   : ra1;
    assign m_rb   = sel ? rb2   : rb1;

    function automatic logic [7:0] pa_m(input logic [5:0] a);
        logic [7:0] x;
        x = {2'b00, a};
        return x * 8'd17;
    endfunction

    function automatic logic [7:0] pb_m(input logic [5:0] a);
        logic [7:0] x;
        x = {2'b00, a};
        return ~(x * 8'd5);
    endfunction

    typedef struct {
        bit sel; int fault; int lat2; int pulse_at;
        int busy; bit fail; bit port; int addr; int e; int g; int nwb;
    } vec_t;

    vec_t vecs[6];
    vec_t exp_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Follows one run to done, checking every write and the idle port on the way.
    task automatic wait_done(input int pulse_at, input bit hold, output int bcnt, output int nwb);
        int wa_i, wb_i;
        bit fin;
        wa_i = 0; wb_i = 0; bcnt = 0; fin = 1'b0;
        @(posedge clk);
        for (int c = 0; c < 2000 && !fin; c++) begin
            @(negedge clk);
            start_v = hold || (pulse_at > 0 && bcnt == pulse_at);
            if (m_wa) begin
                chk("wr_addr_a", m_aa, wa_i);
                chk("wr_data_a", m_da, pa_m(m_aa));
                wa_i++;
            end
            if (m_wb) begin
                chk("wr_addr_b", m_ab, wb_i);
                chk("wr_data_b", m_db, pb_m(m_ab));
                wb_i++;
            end
            if (m_wa || m_ra) chk("idle_port_b", {m_wb, m_rb, m_ab, m_db}, 64'd0);
            if (m_wb || m_rb) chk("idle_port_a", {m_wa, m_ra, m_aa, m_da}, 64'd0);
            if (m_busy) bcnt++;
            if (m_done) fin = 1'b1;
        end
        if (!fin) chk("done_timeout", 64'd0, 64'd1);
        nwb = wb_i;
    endtask

    task automatic run_vec(input vec_t v);
        vec_t e;
        int b, n;
        sel = v.sel; fault = v.fault; lat2 = v.lat2;
        @(negedge clk);
        start_v = 1'b1;
        exp_q.push_back(v);
        wait_done(v.pulse_at, 1'b0, b, n);
        e = exp_q.pop_front();
        chk("busy_cycles", b, e.busy);
        chk("done", m_done, 1'b1);
        chk("busy_at_done", m_busy, 1'b0);
        chk("fail", m_fail, e.fail);
        chk("err_port", m_ep, e.port);
        chk("err_addr", m_ea, e.addr);
        chk("err_exp", m_ee, e.e);
        chk("err_got", m_eg, e.g);
        chk("port_b_writes", n, e.nwb);
        chk("enables_at_done", {m_wa, m_wb, m_ra, m_rb}, 64'd0);
    endtask

    initial begin
        int b, n;
        //          sel fault lat2 pulse busy fail port addr exp    got    nwb
        vecs[0] = '{1'b0, 0, 2, 0,   258, 1'b0, 1'b0, 0, 'h00, 'h00, 64};
        vecs[1] = '{1'b0, 1, 2, 0,    75, 1'b1, 1'b1, 8, 'h88, 'h80,  0};
        vecs[2] = '{1'b0, 2, 2, 0,   197, 1'b1, 1'b0, 1, 'hFA, 'hFF, 64};
        vecs[3] = '{1'b0, 0, 2, 100, 258, 1'b0, 1'b0, 0, 'h00, 'h00, 64};
        vecs[4] = '{1'b1, 0, 2, 0,   260, 1'b0, 1'b0, 0, 'h00, 'h00, 64};
        vecs[5] = '{1'b1, 0, 1, 0,    68, 1'b1, 1'b1, 0, 'h00, 'h11,  0};

        rst_n = 1'b0; start_v = 1'b0; sel = 1'b0; fault = 0; lat2 = 2;
        repeat (3) @(negedge clk);
        chk("reset_outs_1", {busy1, done1, fail1, ep1, ea1, ee1, eg1, aa1, ab1, da1, db1, wa1, wb1, ra1, rb1}, 64'd0);
        chk("reset_outs_2", {busy2, done2, fail2, ep2, ea2, ee2, eg2, aa2, ab2, da2, db2, wa2, wb2, ra2, rb2}, 64'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i]);
        end

        // start held high through DONE restarts straight away.
        sel = 1'b0; fault = 0;
        @(negedge clk);
        start_v = 1'b1;
        wait_done(0, 1'b1, b, n);
        chk("hold_busy_1", b, 258);
        chk("hold_fail_1", {done1, fail1}, 2'b10);
        wait_done(0, 1'b0, b, n);
        chk("hold_busy_2", b, 258);
        chk("hold_fail_2", {done1, fail1}, 2'b10);

        // Reset pulse mid-run (in RD_B) returns everything to zero and stays quiet.
        @(negedge clk);
        start_v = 1'b1;
        @(negedge clk);
        start_v = 1'b0;
        repeat (98) @(negedge clk);
        chk("in_rd_b", {busy1, rb1}, 2'b11);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("rst_mid_outs", {busy1, done1, fail1, ep1, ea1, ee1, eg1, aa1, ab1, da1, db1, wa1, wb1, ra1, rb1}, 64'd0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("quiet_after_rst", {busy1, wa1, wb1, ra1, rb1}, 64'd0);
        end
        run_vec(vecs[0]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
